// File: rtl/alu_cmd_encoder_if.sv
// alu_cmd_encoder_if: host request and tx_module byte handshake bundle
interface alu_cmd_encoder_if;
  logic start;
  logic [7:0] a;
  logic [7:0] b;
  logic [5:0] op;
  logic tx_done_tick;
  logic tx_start;
  logic [7:0] d_in;
  logic busy;
  logic done_tick;
  logic op_err;
  modport master (output start, a, b, op, tx_done_tick, input tx_start, d_in, busy, done_tick, op_err);
  modport slave (input start, a, b, op, tx_done_tick, output tx_start, d_in, busy, done_tick, op_err);
endinterface

// File: rtl/alu_cmd_encoder.sv
// alu_cmd_encoder: encodes a/b/op as an ASCII hex frame and streams it byte by byte to tx_module
module alu_cmd_encoder #(
  parameter bit UPPER_HEX = 1'b0,
  parameter bit SEND_TERM = 1'b1,
  parameter logic [7:0] TERM_CHAR = 8'h0D
) (
  input logic clk,
  input logic reset,
  alu_cmd_encoder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;
  localparam logic [2:0] LAST = SEND_TERM ? 3'd5 : 3'd4;
  state_t state, state_n;
  logic [2:0] idx;
  logic [7:0] a_q, b_q, ch;
  logic [5:0] op_q;
  logic pend, err, take;
  function automatic logic [7:0] hex(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + {4'h0, n} : (UPPER_HEX ? 8'h37 : 8'h57) + {4'h0, n};
  endfunction
  function automatic logic [7:0] op_char(input logic [5:0] o);
    case (o)
      6'b100000: return 8'h2B;
      6'b100010: return 8'h2D;
      6'b100100: return 8'h26;
      6'b100101: return 8'h7C;
      6'b100110: return 8'h5E;
      6'b100111: return 8'h7E;
      6'b000011: return 8'h61;
      6'b000010: return 8'h6C;
      default:   return 8'h3F;
    endcase
  endfunction
  assign take = state == IDLE && !pend && bus.start;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      pend <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      pend <= take;
      if (take) begin
        a_q <= bus.a;
        b_q <= bus.b;
        op_q <= bus.op;
        idx <= '0;
        err <= op_char(bus.op) == 8'h3F;
      end
      if (state == WAIT && bus.tx_done_tick && idx != LAST) idx <= idx + 3'd1;
      if (state == DONE) err <= 1'b0;
    end
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (pend ? LOAD : IDLE)
            : state == LOAD ? WAIT
            : state == WAIT ? (bus.tx_done_tick ? (idx == LAST ? DONE : LOAD) : WAIT)
            : IDLE;
  end
  assign ch = idx == 3'd0 ? hex(a_q[7:4])
            : idx == 3'd1 ? hex(a_q[3:0])
            : idx == 3'd2 ? hex(b_q[7:4])
            : idx == 3'd3 ? hex(b_q[3:0])
            : idx == 3'd4 ? op_char(op_q)
            : TERM_CHAR;
  assign bus.tx_start = state == LOAD;
  assign bus.d_in = (state == LOAD || state == WAIT) ? ch : 8'h00;
  assign bus.busy = pend || state != IDLE;
  assign bus.done_tick = state == DONE;
  assign bus.op_err = err;
endmodule

// File: tb/tb_alu_cmd_encoder.sv
// tb_alu_cmd_encoder: randomized frame-level model check of two encoder configurations
module tb_alu_cmd_encoder;
  logic clk = 1'b0;
  logic reset;
  logic start;
  logic [7:0] a, b;
  logic [5:0] op;
  bit rand_resp;
  int cyc = 0;
  int pass_n = 0, tot_n = 0;
  logic [5:0] ops [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b000011, 6'b000010};
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string nm, input int got, input int exp);
    tot_n++;
    if (got == exp) pass_n++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, exp, cyc);
  endtask
  function automatic logic [7:0] hexc(input int n, input bit up);
    return 8'(n < 10 ? 48 + n : (up ? 65 : 97) + n - 10);
  endfunction
  function automatic logic [7:0] opc(input logic [5:0] o);
    case (o)
      6'b100000: return "+";
      6'b100010: return "-";
      6'b100100: return "&";
      6'b100101: return "|";
      6'b100110: return "^";
      6'b100111: return "~";
      6'b000011: return "a";
      6'b000010: return "l";
      default:   return "?";
    endcase
  endfunction
  function automatic logic [7:0] exp_byte(input int i, input logic [7:0] aa, input logic [7:0] bb, input logic [5:0] oo, input bit up);
    int v;
    v = {16'h0, aa, bb};
    if (i < 4) return hexc((v >> (12 - 4 * i)) & 15, up);
    return i == 4 ? opc(oo) : 8'h0D;
  endfunction
  for (genvar g = 0; g < 2; g++) begin : gi
    localparam bit UP = (g == 1);
    localparam bit TERM = (g == 0);
    alu_cmd_encoder_if bus ();
    logic tdt = 1'b0;
    int cnt = 0;
    logic [7:0] fq[$], cap[$], last_frame[$];
    bit mbusy = 0, merr = 0, inflight = 0;
    int nxt_tx = -1, tx_cyc = -1, done_at = -1, t_acc = 0, lat = -1, n_tx = 0, n_done = 0, n = 0;
    assign bus.start = start;
    assign bus.a = a;
    assign bus.b = b;
    assign bus.op = op;
    assign bus.tx_done_tick = tdt;
    alu_cmd_encoder #(.UPPER_HEX(UP), .SEND_TERM(TERM), .TERM_CHAR(8'h0D)) dut (.clk(clk), .reset(reset), .bus(bus));
    always @(negedge clk) begin
      #1;
      if (bus.tx_start) begin
        cnt = rand_resp ? int'($urandom_range(1, 4)) : 3;
        tdt = rand_resp && ($urandom_range(0, 3) == 0);
      end else if (cnt > 0) begin
        cnt--;
        tdt = (cnt == 0);
      end else tdt = rand_resp && ($urandom_range(0, 15) == 0);
    end
    always @(negedge clk) begin
      if (reset) begin
        fq.delete();
        cap.delete();
        mbusy = 0;
        merr = 0;
        inflight = 0;
        nxt_tx = -1;
        tx_cyc = -1;
        done_at = -1;
      end else begin
        n = cyc;
        if (start && !mbusy) begin
          fq.delete();
          for (int i = 0; i < (TERM ? 6 : 5); i++) fq.push_back(exp_byte(i, a, b, op, UP));
          merr = (opc(op) == "?");
          mbusy = 1;
          nxt_tx = n + 1;
          t_acc = n - 1;
        end
        if (bus.tx_done_tick && inflight && n - 1 > tx_cyc) begin
          fq.delete(0);
          inflight = 0;
          if (fq.size() == 0) done_at = n;
          else nxt_tx = n;
        end
        if (n == done_at + 1) begin
          mbusy = 0;
          merr = 0;
        end
        if (n == nxt_tx) begin
          inflight = 1;
          tx_cyc = n;
        end
        chk($sformatf("i%0d tx_start", g), bus.tx_start, n == tx_cyc);
        if (inflight) chk($sformatf("i%0d d_in", g), bus.d_in, fq[0]);
        chk($sformatf("i%0d busy", g), bus.busy, mbusy);
        chk($sformatf("i%0d done_tick", g), bus.done_tick, n == done_at);
        chk($sformatf("i%0d op_err", g), bus.op_err, merr);
        if (bus.tx_start) begin
          if (cap.size() == 0) lat = n - t_acc;
          cap.push_back(bus.d_in);
          n_tx++;
        end
        if (bus.done_tick) begin
          last_frame = cap;
          cap.delete();
          n_done++;
        end
      end
    end
  end
  task automatic chk_frame(input string nm, input logic [7:0] got[$], input logic [7:0] e[6], input int len);
    chk({nm, " len"}, got.size(), len);
    for (int i = 0; i < len; i++) chk($sformatf("%s byte%0d", nm, i), i < got.size() ? int'(got[i]) : -1, e[i]);
  endtask
  task automatic chk_zero(input string nm, input logic ts, input logic [7:0] d, input logic bz, input logic dt, input logic oe);
    chk({nm, " tx_start"}, ts, 0);
    chk({nm, " d_in"}, d, 0);
    chk({nm, " busy"}, bz, 0);
    chk({nm, " done_tick"}, dt, 0);
    chk({nm, " op_err"}, oe, 0);
  endtask
  task automatic send(input logic [7:0] aa, input logic [7:0] bb, input logic [5:0] oo);
    @(negedge clk);
    #1;
    a = aa;
    b = bb;
    op = oo;
    start = 1;
    @(negedge clk);
    #1;
    start = 0;
  endtask
  task automatic wait_idle();
    int k;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      #2;
      if (!gi[0].bus.busy && !gi[1].bus.busy) break;
    end
    chk("idle wait bound", k < 400, 1);
  endtask
  task automatic wait_tx(input int target);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      #2;
      if (gi[0].n_tx >= target) break;
    end
    chk("tx_start wait bound", k < 200, 1);
  endtask
  task automatic wait_done();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      #2;
      if (gi[0].bus.done_tick) break;
    end
    chk("done_tick wait bound", k < 200, 1);
  endtask
  initial begin
    int bt, bd, mode;
    reset = 0;
    start = 0;
    a = 0;
    b = 0;
    op = 0;
    rand_resp = 0;
    #1 reset = 1;
    chk("model hex 5", hexc(5, 0), 8'h35);
    chk("model hex f", hexc(15, 0), 8'h66);
    chk("model hex B upper", hexc(11, 1), 8'h42);
    chk("model op not", opc(6'b100111), 8'h7E);
    chk("model op bad", opc(6'b111111), 8'h3F);
    chk("model byte3", exp_byte(3, 8'h00, 8'h09, 6'b000011, 0), 8'h39);
    repeat (3) @(negedge clk);
    #2;
    chk_zero("reset i0", gi[0].bus.tx_start, gi[0].bus.d_in, gi[0].bus.busy, gi[0].bus.done_tick, gi[0].bus.op_err);
    chk_zero("reset i1", gi[1].bus.tx_start, gi[1].bus.d_in, gi[1].bus.busy, gi[1].bus.done_tick, gi[1].bus.op_err);
    @(negedge clk);
    #1 reset = 0;
    send(8'h5F, 8'h10, 6'b100000);
    wait_idle();
    chk_frame("T1 i0", gi[0].last_frame, '{8'h35, 8'h66, 8'h31, 8'h30, 8'h2B, 8'h0D}, 6);
    chk_frame("T1 i1", gi[1].last_frame, '{8'h35, 8'h46, 8'h31, 8'h30, 8'h2B, 8'h00}, 5);
    chk("T1 latency", gi[0].lat, 2);
    chk("T1 done count", gi[0].n_done, 1);
    send(8'hAB, 8'hFE, 6'b100110);
    wait_idle();
    chk_frame("T2 i1", gi[1].last_frame, '{8'h41, 8'h42, 8'h46, 8'h45, 8'h5E, 8'h00}, 5);
    chk_frame("T2 i0", gi[0].last_frame, '{8'h61, 8'h62, 8'h66, 8'h65, 8'h5E, 8'h0D}, 6);
    send(8'h12, 8'h34, 6'b111111);
    chk("T3 op_err set", gi[0].bus.op_err, 1);
    wait_idle();
    chk("T3 op_err cleared", gi[0].bus.op_err, 0);
    chk_frame("T3 i0", gi[0].last_frame, '{8'h31, 8'h32, 8'h33, 8'h34, 8'h3F, 8'h0D}, 6);
    bt = gi[0].n_tx;
    bd = gi[0].n_done;
    send(8'hC3, 8'h7E, 6'b000010);
    wait_tx(bt + 2);
    @(negedge clk);
    #1;
    a = 8'hFF;
    b = 8'h00;
    op = 6'b100000;
    start = 1;
    @(negedge clk);
    #1 start = 0;
    wait_idle();
    chk_frame("T4 i0", gi[0].last_frame, '{8'h63, 8'h33, 8'h37, 8'h65, 8'h6C, 8'h0D}, 6);
    chk("T4 tx_start count", gi[0].n_tx - bt, 6);
    chk("T4 done count", gi[0].n_done - bd, 1);
    bt = gi[0].n_tx;
    send(8'h9A, 8'hBC, 6'b100101);
    wait_tx(bt + 3);
    @(negedge clk);
    #2;
    chk("T5 busy before reset", gi[0].bus.busy, 1);
    reset = 1;
    #1;
    chk_zero("T5 i0", gi[0].bus.tx_start, gi[0].bus.d_in, gi[0].bus.busy, gi[0].bus.done_tick, gi[0].bus.op_err);
    @(negedge clk);
    #1 reset = 0;
    bt = gi[0].n_tx;
    repeat (8) @(negedge clk);
    chk("T5 no tx_start after reset", gi[0].n_tx, bt);
    send(8'h9A, 8'hBC, 6'b100101);
    wait_idle();
    chk_frame("T5 i0", gi[0].last_frame, '{8'h39, 8'h61, 8'h62, 8'h63, 8'h7C, 8'h0D}, 6);
    send(8'h00, 8'h09, 6'b000011);
    wait_idle();
    chk_frame("T6 i1", gi[1].last_frame, '{8'h30, 8'h30, 8'h30, 8'h39, 8'h61, 8'h00}, 5);
    chk("T6 latency", gi[1].lat, 2);
    rand_resp = 1;
    for (int f = 0; f < 60; f++) begin
      send(8'($urandom), 8'($urandom), $urandom_range(0, 1) ? ops[$urandom_range(0, 7)] : 6'($urandom));
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        a = 8'($urandom);
        b = 8'($urandom);
        op = 6'($urandom);
      end
      if (mode == 1) begin
        repeat ($urandom_range(1, 25)) @(negedge clk);
        #1;
        a = 8'($urandom);
        b = 8'($urandom);
        op = 6'($urandom);
        start = 1;
        @(negedge clk);
        #1 start = 0;
      end
      if (mode == 2) begin
        wait_done();
        a = 8'($urandom);
        b = 8'($urandom);
        start = 1;
        @(negedge clk);
        #1 start = 0;
      end
      wait_idle();
    end
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
